// File: rtl/dm_ctrl_pkg.sv
// Shared parameters, state encoding and address legality helper for the data-memory controller.
package dm_ctrl_pkg;

  localparam int unsigned DM_DEPTH_WORDS  = 32'h3000;
  localparam int unsigned DM_STARVE_LIMIT = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Word-aligned and inside the memory.
  function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/dm_ctrl_arb.sv
// CPU/debug arbiter: CPU priority, debug force-granted after STARVE_LIMIT denied cycles.
// Grants are combinational in the request cycle; a denied requester holds until granted.
module dm_ctrl_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  input  logic cpu_req,
  input  logic dbg_req,
  output logic cpu_gnt,
  output logic dbg_gnt
);

  localparam int W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(STARVE_LIMIT);

  logic [W-1:0] wait_cnt;
  logic         force_dbg;

  assign force_dbg = dbg_req && (wait_cnt == LIMIT);
  assign cpu_gnt   = run && cpu_req && !force_dbg;
  assign dbg_gnt   = run && dbg_req && (!cpu_req || force_dbg);

  // Counter only advances on RUN edges; leaving RUN for CLEAR restarts it.
  always_ff @(posedge clk) begin
    if (reset || !run || clr) begin
      wait_cnt <= '0;
    end else if (dbg_req && !dbg_gnt) begin
      if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: zeroes the memory after reset/clr_req, then arbitrates CPU and debug ports.
// Zero-latency reads, single-cycle writes; busy while clearing, denied requesters hold until granted.
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = DM_DEPTH_WORDS,
  parameter int unsigned STARVE_LIMIT = DM_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_req,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_err,
  output logic [31:0] dbg_rdata,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic        busy
);

  localparam int CNT_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DEPTH_WORDS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] clr_cnt, clr_cnt_nxt;
  logic             run_en;
  logic             cpu_legal, dbg_legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_CLEAR: begin
        if (clr_cnt == LAST_WORD) begin
          state_nxt   = ST_RUN;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (clr_req) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = ST_CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // Reset gates grants so an access presented alongside reset never writes.
  assign run_en = (state == ST_RUN) && !reset;
  assign busy   = (state == ST_CLEAR);

  dm_ctrl_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .run     (run_en),
    .clr     (clr_req),
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .cpu_gnt (cpu_gnt),
    .dbg_gnt (dbg_gnt)
  );

  assign cpu_legal = addr_legal(cpu_addr, 32'(DEPTH_WORDS));
  assign dbg_legal = addr_legal(dbg_addr, 32'(DEPTH_WORDS));

  always_comb begin
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    cpu_rdata = '0;
    cpu_err   = 1'b0;
    dbg_rdata = '0;
    dbg_err   = 1'b0;
    if (state == ST_CLEAR) begin
      dm_we   = 1'b1;
      dm_addr = 32'(clr_cnt) << 2;
    end else if (cpu_gnt) begin
      dm_addr   = cpu_addr;
      dm_wdata  = cpu_wdata;
      dm_we     = cpu_we && cpu_legal;
      cpu_err   = !cpu_legal;
      cpu_rdata = cpu_legal ? dm_rdata : 32'h0;
    end else if (dbg_gnt) begin
      dm_addr   = dbg_addr;
      dm_wdata  = dbg_wdata;
      dm_we     = dbg_we && dbg_legal;
      dbg_err   = !dbg_legal;
      dbg_rdata = dbg_legal ? dm_rdata : 32'h0;
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed and randomized checks of dm_ctrl against a word-array memory and a spec-level reference model.
module tb_dm_ctrl;

  localparam int DEPTH = 12288;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset, clr_req;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_err, dbg_gnt, dbg_err;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        dm_we, busy;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] exp_mem [0:DEPTH-1];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_ctrl #(.DEPTH_WORDS(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .busy(busy)
  );

  // Combinational-read, posedge-write data memory.
  assign dm_rdata = (dm_addr[31:2] < DEPTH) ? mem[dm_addr[15:2]] : 32'h0;
  always @(posedge clk) if (dm_we && dm_addr[31:2] < DEPTH) mem[dm_addr[15:2]] <= dm_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < DEPTH);
  endfunction

  function automatic logic [31:0] rand_addr();
    int r, w;
    r = $urandom_range(0, 7);
    w = ($urandom % 2 == 0) ? $urandom_range(0, 15) : DEPTH - 1 - $urandom_range(0, 3);
    if (r == 0) return 32'(DEPTH * 4 + $urandom_range(0, 3) * 4);
    if (r == 1) return 32'(w * 4 + $urandom_range(1, 3));
    return 32'(w * 4);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
  endtask

  // Checks n CLEAR cycles starting at word 0; entered and left at a negedge.
  task automatic clear_run(input int n, input bit hold_reqs);
    if (hold_reqs) begin
      cpu_req = 1'b1; dbg_req = 1'b1; clr_req = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      #1;
      check("clear_seq", {28'b0, busy, dm_we, cpu_gnt | dbg_gnt, |dm_wdata, dm_addr},
            {28'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'(i * 4)});
      if (i == n - 1) begin
        cpu_req = 1'b0; dbg_req = 1'b0; clr_req = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    bit          cpu_hold, dbg_hold, frc, ecg, edg;
    int          starve;
    logic [31:0] e_rd;

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    reset = 1'b1; clr_req = 1'b0;
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;

    // Reset state and full clear after reset
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", {61'b0, busy, cpu_gnt, dbg_gnt}, {61'b0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    clear_run(DEPTH, 1'b0);
    model_clear();
    #1 check("busy_after_clear", 64'(busy), 64'(0));

    // CPU write then read
    cpu_drive(1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
    #1 check("wr_gnt", {62'b0, cpu_gnt, dm_we}, {62'b0, 1'b1, 1'b1});
    check("wr_err", 64'(cpu_err), 64'(0));
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, 32'h100, 32'h0);
    #1 check("rd_gnt", 64'(cpu_gnt), 64'(1));
    check("rd_data", 64'(cpu_rdata), 64'(32'hDEADBEEF));
    check("rd_err", 64'(cpu_err), 64'(0));
    exp_mem[32'h40] = 32'hDEADBEEF;
    @(negedge clk);

    // Starvation: CPU wins 4 cycles, debug forced on the 5th
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h4;
    for (int k = 1; k <= 10; k++) begin
      #1 check("starve_cpu_gnt", 64'(cpu_gnt), 64'(k % 5 != 0));
      check("starve_dbg_gnt", 64'(dbg_gnt), 64'(k % 5 == 0));
      @(negedge clk);
    end
    dbg_req = 1'b0;

    // Illegal accesses
    cpu_drive(1'b1, 1'b1, 32'hC000, 32'h55555555);
    #1 check("oob_err", {61'b0, cpu_gnt, cpu_err, dm_we}, {61'b0, 1'b1, 1'b1, 1'b0});
    check("oob_rdata", 64'(cpu_rdata), 64'(0));
    @(negedge clk);
    cpu_drive(1'b1, 1'b1, 32'h102, 32'h11111111);
    #1 check("misalign_err", {61'b0, cpu_gnt, cpu_err, dm_we}, {61'b0, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, 32'h100, 32'h0);
    #1 check("unchanged", 64'(cpu_rdata), 64'(32'hDEADBEEF));
    @(negedge clk);
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    dbg_req = 1'b1; dbg_addr = 32'hBFFC;
    #1 check("dbg_last_word", {31'b0, dbg_gnt, dbg_err, dbg_rdata}, {31'b0, 1'b1, 1'b0, 32'h0});
    @(negedge clk);
    dbg_req = 1'b0;

    // Randomized traffic against the reference model
    cpu_hold = 1'b0; dbg_hold = 1'b0; starve = 0;
    for (int n = 0; n < 400; n++) begin
      if (!cpu_hold) cpu_drive(1'($urandom % 3 != 0), 1'($urandom % 2), rand_addr(), $urandom);
      if (!dbg_hold) begin
        dbg_req = 1'($urandom % 2); dbg_we = 1'($urandom % 2);
        dbg_addr = rand_addr(); dbg_wdata = $urandom;
      end
      #1;
      frc = dbg_req && (starve == LIMIT);
      ecg = cpu_req && !frc;
      edg = dbg_req && (!cpu_req || frc);
      check("rnd_cpu_gnt", 64'(cpu_gnt), 64'(ecg));
      check("rnd_dbg_gnt", 64'(dbg_gnt), 64'(edg));
      e_rd = (ecg && legal(cpu_addr)) ? exp_mem[cpu_addr >> 2] : 32'h0;
      check("rnd_cpu_rdata", {31'b0, cpu_err, cpu_rdata}, {31'b0, ecg && !legal(cpu_addr), e_rd});
      e_rd = (edg && legal(dbg_addr)) ? exp_mem[dbg_addr >> 2] : 32'h0;
      check("rnd_dbg_rdata", {31'b0, dbg_err, dbg_rdata}, {31'b0, edg && !legal(dbg_addr), e_rd});
      check("rnd_dm_we", 64'(dm_we),
            64'((ecg && cpu_we && legal(cpu_addr)) || (edg && dbg_we && legal(dbg_addr))));
      if (ecg && cpu_we && legal(cpu_addr)) exp_mem[cpu_addr >> 2] = cpu_wdata;
      if (edg && dbg_we && legal(dbg_addr)) exp_mem[dbg_addr >> 2] = dbg_wdata;
      starve   = (dbg_req && !edg) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
      cpu_hold = cpu_req && !ecg;
      dbg_hold = dbg_req && !edg;
      @(negedge clk);
    end
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    dbg_req = 1'b0;
    @(negedge clk);

    // clr_req with a simultaneous write: write lands, then everything clears
    cpu_drive(1'b1, 1'b1, 32'h8, 32'h12345678);
    clr_req = 1'b1;
    #1 check("clr_wr_gnt", {30'b0, cpu_gnt, dm_we, dm_addr}, {30'b0, 1'b1, 1'b1, 32'h8});
    @(negedge clk);
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1 check("clr_wr_landed", 64'(mem[2]), 64'(32'h12345678));
    clear_run(DEPTH, 1'b1);
    model_clear();
    #1 check("busy_after_clr", 64'(busy), 64'(0));
    cpu_drive(1'b1, 1'b0, 32'h8, 32'h0);
    #1 check("rd_after_clr", {31'b0, cpu_gnt, cpu_rdata}, {31'b0, 1'b1, 32'h0});
    @(negedge clk);

    // Reset mid-RUN with a pending write, then reset again mid-CLEAR
    e_rd = mem[4];
    reset = 1'b1;
    cpu_drive(1'b1, 1'b1, 32'h10, 32'hA5A5A5A5);
    #1 check("reset_blocks_wr", {62'b0, cpu_gnt, dm_we}, {62'b0, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1 check("reset_no_write", 64'(mem[4]), 64'(e_rd));
    clear_run(100, 1'b0);
    reset = 1'b1;
    #1 check("busy_mid_clear", 64'(busy), 64'(1));
    @(negedge clk);
    reset = 1'b0;
    clear_run(DEPTH, 1'b0);
    #1 check("busy_after_restart", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
